pfl1monitor: RTL and testbench

//  Upstream feeder of the prefetch monitor. Observes L1 demand accesses and

---
 rtl/pfl1monitor_pkg.sv | 30 +++
 rtl/pfl1monitor_if.sv | 31 +++
 rtl/pfl1mon_fifo.sv | 61 ++++++
 rtl/pfl1monitor.sv | 161 ++++++++++++++++
 tb/tb_pfl1monitor.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/pfl1monitor_pkg.sv
// pfl1monitor_pkg
// Shared widths, page/line shift constants, and the packed record types for the
// observation and candidate channels of pfl1monitor. It also holds the saturating
// confidence helper.
package pfl1monitor_pkg;

  localparam int ADDR_W     = 50;
  localparam int PC_W       = 50;
  localparam int PAGE_SHIFT = 12;
  localparam int LINE_SHIFT = 6;

  // Demand access observed at the L1
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [ADDR_W-1:0] addr;
    logic              miss;
  } I_l1topfl1_obs_type;

  // Prefetch candidate handed to the prefetch monitor
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        conf;
  } I_pfl1tomon_cand_type;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'd3) ? 2'd3 : c + 2'd1;
  endfunction

endpackage

// File: rtl/pfl1monitor_if.sv
// pfl1monitor_if
// Bundles the two valid/retry channels of the L1 stride prefetcher.
//   l1topfl1_obs / _valid / _retry     : demand observations, L1 -> monitor
//   pfl1tomon_cand / _valid / _retry   : prefetch candidates, monitor -> consumer
// Modport slave is the prefetcher's view. Modport master is the surrounding
// environment's view.
interface pfl1monitor_if;
  import pfl1monitor_pkg::*;

  I_l1topfl1_obs_type   l1topfl1_obs;
  logic                 l1topfl1_obs_valid;
  logic                 l1topfl1_obs_retry;
  I_pfl1tomon_cand_type pfl1tomon_cand;
  logic                 pfl1tomon_cand_valid;
  logic                 pfl1tomon_cand_retry;

  modport slave (
    input  l1topfl1_obs, l1topfl1_obs_valid,
    output l1topfl1_obs_retry,
    output pfl1tomon_cand, pfl1tomon_cand_valid,
    input  pfl1tomon_cand_retry
  );

  modport master (
    output l1topfl1_obs, l1topfl1_obs_valid,
    input  l1topfl1_obs_retry,
    input  pfl1tomon_cand, pfl1tomon_cand_valid,
    output pfl1tomon_cand_retry
  );

endinterface

// File: rtl/pfl1mon_fifo.sv
// pfl1mon_fifo
// Generic valid/retry FIFO. A transfer happens on valid && !retry on each side.
// Ports:
//   clk, reset          clock, async active-high reset (empties the FIFO)
//   in_valid/in_retry   write side; in_retry is "full" from the registered count
//   in_data             write data
//   out_valid/out_retry read side; out_valid is "not empty"
//   out_data            head entry
// DEPTH must be a power of two, so the pointers wrap naturally.
module pfl1mon_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_retry,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_retry,
  output logic [WIDTH-1:0] out_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  assign in_retry  = (count == CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && !in_retry;
  assign pop       = out_valid && !out_retry;
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      // A simultaneous push and pop leaves the occupancy unchanged
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/pfl1monitor.sv
// pfl1monitor
// Watches L1 demand accesses and trains a direct-mapped, PC-indexed stride table.
// Confident strides produce prefetch candidates, which queue in a small FIFO
// toward the prefetch monitor. L1 lookups are never stalled. Only the
// observation port is backpressured, and it retries while the FIFO is full.
// Ports:
//   clk    clock
//   reset  async active-high reset (clears table valid bits and the FIFO)
//   bus    pfl1monitor_if.slave (observation in, candidate out)
// Configuration:
//   PFL1MON_DEDUP_EN  when defined, a candidate that falls on the same 64B line
//                     as the last pushed candidate is dropped
module pfl1monitor
  import pfl1monitor_pkg::*;
#(
  parameter int TBL_LOG2   = 4,
  parameter int TAG_W      = 10,
  parameter int STRIDE_W   = 16,
  parameter int CONF_TH    = 2,
  parameter int DIST_LOG2  = 0,
  parameter int FIFO_DEPTH = 2
) (
  input logic          clk,
  input logic          reset,
  pfl1monitor_if.slave bus
);

  localparam int         ENTRIES  = 1 << TBL_LOG2;
  localparam int         TAG_LO   = TBL_LOG2 + 2;
  localparam int         CAND_W   = $bits(I_pfl1tomon_cand_type);
  localparam logic [1:0] CONF_MIN = 2'(CONF_TH);

  logic [ENTRIES-1:0]  tbl_valid;
  logic [TAG_W-1:0]    tbl_tag    [ENTRIES];
  logic [ADDR_W-1:0]   tbl_last   [ENTRIES];
  logic [STRIDE_W-1:0] tbl_stride [ENTRIES];
  logic [1:0]          tbl_conf   [ENTRIES];

  I_l1topfl1_obs_type   obs;
  I_pfl1tomon_cand_type cand_in;
  I_pfl1tomon_cand_type cand_out;
  logic [TBL_LOG2-1:0]  idx;
  logic [TAG_W-1:0]     tag;
  logic                 hit;
  logic                 fits;
  logic                 emit;
  logic                 accept;
  logic                 push;
  logic                 obs_retry;
  logic [ADDR_W-1:0]    delta;
  logic [ADDR_W-1:0]    step;
  logic [ADDR_W-1:0]    cand_addr;
  logic [STRIDE_W-1:0]  cur_stride;
  logic [STRIDE_W-1:0]  new_stride;
  logic [1:0]           cur_conf;
  logic [1:0]           new_conf;
  logic                 unused_miss;

  assign obs         = bus.l1topfl1_obs;
  assign unused_miss = obs.miss;
  assign idx         = obs.pc[TBL_LOG2+1:2];
  assign tag         = obs.pc[TAG_LO+TAG_W-1:TAG_LO];
  assign hit         = tbl_valid[idx] && (tbl_tag[idx] == tag);
  assign cur_stride  = tbl_stride[idx];
  assign cur_conf    = tbl_conf[idx];
  assign accept      = bus.l1topfl1_obs_valid && !obs_retry;

  assign bus.l1topfl1_obs_retry = obs_retry;

  // The table is written at the accepting edge. The next observation reads the
  // updated entry directly, so back-to-back hits on one index need no bypass.
  assign delta = obs.addr - tbl_last[idx];
  // A delta fits the signed stride only if every bit from the stride sign bit
  // upward matches that sign bit.
  assign fits  = (&delta[ADDR_W-1:STRIDE_W-1]) || !(|delta[ADDR_W-1:STRIDE_W-1]);

  // Post-update stride/confidence. A miss-tag reallocates with zeroes, and so
  // does an unrepresentable jump.
  always_comb begin
    new_stride = cur_stride;
    new_conf   = cur_conf;
    if (!hit || !fits) begin
      new_stride = '0;
      new_conf   = 2'd0;
    end else if (delta[STRIDE_W-1:0] == cur_stride) begin
      new_conf = sat_inc(cur_conf);
    end else if (cur_conf != 2'd0) begin
      new_conf = cur_conf - 2'd1;
    end else begin
      new_stride = delta[STRIDE_W-1:0];
    end
  end

  // Sign-extended stride scaled by the prefetch distance. The add wraps modulo
  // 2^ADDR_W, so a wrap past zero shows up as a page change.
  assign step      = {{(ADDR_W-STRIDE_W){new_stride[STRIDE_W-1]}}, new_stride} << DIST_LOG2;
  assign cand_addr = obs.addr + step;
  assign emit      = hit && (new_stride != '0) && (new_conf >= CONF_MIN) &&
                     (cand_addr[ADDR_W-1:PAGE_SHIFT] == obs.addr[ADDR_W-1:PAGE_SHIFT]);

  assign cand_in.pc   = obs.pc;
  assign cand_in.addr = cand_addr;
  assign cand_in.conf = new_conf;

`ifdef PFL1MON_DEDUP_EN
  logic [ADDR_W-LINE_SHIFT-1:0] last_line;
  logic                         last_line_valid;
  logic                         dup;

  assign dup  = last_line_valid && (cand_addr[ADDR_W-1:LINE_SHIFT] == last_line);
  assign push = accept && emit && !dup;

  // Remembers the line of the most recent candidate actually pushed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_line       <= '0;
      last_line_valid <= 1'b0;
    end else if (push) begin
      last_line       <= cand_addr[ADDR_W-1:LINE_SHIFT];
      last_line_valid <= 1'b1;
    end
  end
`else
  assign push = accept && emit;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tbl_valid <= '0;
    end else if (accept) begin
      tbl_valid[idx] <= 1'b1;
    end
  end

  // Entry payload is only meaningful behind its valid bit, so it skips reset
  always_ff @(posedge clk) begin
    if (accept) begin
      tbl_tag[idx]    <= tag;
      tbl_last[idx]   <= obs.addr;
      tbl_stride[idx] <= new_stride;
      tbl_conf[idx]   <= new_conf;
    end
  end

  pfl1mon_fifo #(
    .WIDTH (CAND_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (push),
    .in_retry  (obs_retry),
    .in_data   (cand_in),
    .out_valid (bus.pfl1tomon_cand_valid),
    .out_retry (bus.pfl1tomon_cand_retry),
    .out_data  (cand_out)
  );

  assign bus.pfl1tomon_cand = cand_out;

endmodule

// File: tb/tb_pfl1monitor.sv
// tb_pfl1monitor
// Directed vectors for the L1 stride prefetcher. The vectors cover stride
// training, the page-cross drop, confidence decay, reallocation, unrepresentable
// jumps, negative strides and wrap past zero. Hand sequences cover
// backpressure with an in-order drain, asynchronous reset while full, and
// per-line dedup, whose expectations follow PFL1MON_DEDUP_EN.
module tb_pfl1monitor;
  import pfl1monitor_pkg::*;

`ifdef PFL1MON_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  typedef struct {
    logic [PC_W-1:0]   pc;
    logic [ADDR_W-1:0] addr;
    logic              exp_valid;
    logic [ADDR_W-1:0] exp_addr;
    logic [1:0]        exp_conf;
  } vec_t;

  localparam logic [PC_W-1:0] PC0 = 50'h400;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];

  pfl1monitor_if bus();

  pfl1monitor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic [PC_W-1:0] pc, input logic [ADDR_W-1:0] addr,
                              input logic v, input logic [ADDR_W-1:0] ea, input logic [1:0] ec);
    vec_t r;
    r.pc        = pc;
    r.addr      = addr;
    r.exp_valid = v;
    r.exp_addr  = ea;
    r.exp_conf  = ec;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents one observation at the falling edge; valid stays up until cleared
  task automatic applyStimulus(input logic [PC_W-1:0] pc, input logic [ADDR_W-1:0] addr);
    @(negedge clk);
    bus.l1topfl1_obs       = '{pc: pc, addr: addr, miss: 1'b1};
    bus.l1topfl1_obs_valid = 1'b1;
  endtask

  task automatic checkOutput(input string name, input logic v, input logic [PC_W-1:0] pc,
                             input logic [ADDR_W-1:0] addr, input logic [1:0] conf);
    check({name, ".valid"}, 64'(bus.pfl1tomon_cand_valid), 64'(v));
    if (v) begin
      check({name, ".addr"}, 64'(bus.pfl1tomon_cand.addr), 64'(addr));
      check({name, ".conf"}, 64'(bus.pfl1tomon_cand.conf), 64'(conf));
      check({name, ".pc"},   64'(bus.pfl1tomon_cand.pc),   64'(pc));
    end
  endtask

  // One accepted observation per cycle. With the consumer ready, the candidate
  // of row i is the FIFO head just after the edge that accepts row i.
  task automatic runVectors(input string label);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].pc, vecs[i].addr);
      check($sformatf("%s[%0d].obs_retry", label, i), 64'(bus.l1topfl1_obs_retry), 64'd0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("%s[%0d]", label, i), vecs[i].exp_valid, vecs[i].pc,
                  vecs[i].exp_addr, vecs[i].exp_conf);
    end
    vecs.delete();
    @(negedge clk);
    bus.l1topfl1_obs_valid = 1'b0;
    @(posedge clk);
    #1;
    check({label, ".drained"}, 64'(bus.pfl1tomon_cand_valid), 64'd0);
  endtask

  initial begin
    reset                    = 1'b1;
    bus.l1topfl1_obs         = '0;
    bus.l1topfl1_obs_valid   = 1'b0;
    bus.pfl1tomon_cand_retry = 1'b0;
    #12;
    check("reset.cand_valid", 64'(bus.pfl1tomon_cand_valid), 64'd0);
    check("reset.obs_retry",  64'(bus.l1topfl1_obs_retry),   64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Stride 0x40 training, page-cross drop, confidence decay and retrain
    vecs.push_back(mk(PC0, 50'h1000, 1'b0, 50'h0,    2'd0));
    vecs.push_back(mk(PC0, 50'h1040, 1'b0, 50'h0,    2'd0));
    vecs.push_back(mk(PC0, 50'h1080, 1'b0, 50'h0,    2'd0));
    vecs.push_back(mk(PC0, 50'h10C0, 1'b1, 50'h1100, 2'd2));
    vecs.push_back(mk(PC0, 50'h1100, 1'b1, 50'h1140, 2'd3));
    vecs.push_back(mk(PC0, 50'h1FC0, 1'b0, 50'h0,    2'd0));
    vecs.push_back(mk(PC0, 50'h2000, 1'b1, 50'h2040, 2'd3));
    vecs.push_back(mk(PC0, 50'h2100, 1'b1, 50'h2140, 2'd2));
    vecs.push_back(mk(PC0, 50'h2200, 1'b0, 50'h0,    2'd0));
    vecs.push_back(mk(PC0, 50'h2300, 1'b0, 50'h0,    2'd0));
    vecs.push_back(mk(PC0, 50'h2400, 1'b0, 50'h0,    2'd0));
    vecs.push_back(mk(PC0, 50'h2500, 1'b0, 50'h0,    2'd0));
    vecs.push_back(mk(PC0, 50'h2600, 1'b1, 50'h2700, 2'd2));
    // Same index, different tag: every access reallocates
    vecs.push_back(mk(50'h440, 50'h3000, 1'b0, 50'h0, 2'd0));
    vecs.push_back(mk(PC0,     50'h3040, 1'b0, 50'h0, 2'd0));
    vecs.push_back(mk(50'h440, 50'h3080, 1'b0, 50'h0, 2'd0));
    vecs.push_back(mk(PC0,     50'h30C0, 1'b0, 50'h0, 2'd0));
    vecs.push_back(mk(50'h440, 50'h3100, 1'b0, 50'h0, 2'd0));
    vecs.push_back(mk(PC0,     50'h3140, 1'b0, 50'h0, 2'd0));
    // Jump too large for a 16-bit stride clears the training
    vecs.push_back(mk(50'h408, 50'h8000,  1'b0, 50'h0,     2'd0));
    vecs.push_back(mk(50'h408, 50'h8010,  1'b0, 50'h0,     2'd0));
    vecs.push_back(mk(50'h408, 50'h8020,  1'b0, 50'h0,     2'd0));
    vecs.push_back(mk(50'h408, 50'h8030,  1'b1, 50'h8040,  2'd2));
    vecs.push_back(mk(50'h408, 50'h20000, 1'b0, 50'h0,     2'd0));
    vecs.push_back(mk(50'h408, 50'h20010, 1'b0, 50'h0,     2'd0));
    vecs.push_back(mk(50'h408, 50'h20020, 1'b0, 50'h0,     2'd0));
    vecs.push_back(mk(50'h408, 50'h20030, 1'b1, 50'h20040, 2'd2));
    // Negative stride
    vecs.push_back(mk(50'h40C, 50'h9100, 1'b0, 50'h0,    2'd0));
    vecs.push_back(mk(50'h40C, 50'h90F0, 1'b0, 50'h0,    2'd0));
    vecs.push_back(mk(50'h40C, 50'h90E0, 1'b0, 50'h0,    2'd0));
    vecs.push_back(mk(50'h40C, 50'h90D0, 1'b1, 50'h90C0, 2'd2));
    // Negative stride wrapping below zero is dropped
    vecs.push_back(mk(50'h410, 50'h60, 1'b0, 50'h0, 2'd0));
    vecs.push_back(mk(50'h410, 50'h40, 1'b0, 50'h0, 2'd0));
    vecs.push_back(mk(50'h410, 50'h20, 1'b0, 50'h0, 2'd0));
    vecs.push_back(mk(50'h410, 50'h00, 1'b0, 50'h0, 2'd0));
    runVectors("train");

    // Consumer stalled: two candidates queue, then observations are retried
    bus.pfl1tomon_cand_retry = 1'b1;
    applyStimulus(PC0, 50'h3180);
    @(posedge clk); #1;
    checkOutput("hold.t1", 1'b0, PC0, 50'h0, 2'd0);
    applyStimulus(PC0, 50'h31C0);
    @(posedge clk); #1;
    checkOutput("hold.t2", 1'b0, PC0, 50'h0, 2'd0);
    applyStimulus(PC0, 50'h3200);
    @(posedge clk); #1;
    checkOutput("hold.first", 1'b1, PC0, 50'h3240, 2'd2);
    applyStimulus(PC0, 50'h3240);
    check("hold.retry_before_full", 64'(bus.l1topfl1_obs_retry), 64'd0);
    @(posedge clk); #1;
    checkOutput("hold.second", 1'b1, PC0, 50'h3240, 2'd2);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(PC0, 50'h3280);
      check($sformatf("hold.full[%0d].obs_retry", k), 64'(bus.l1topfl1_obs_retry), 64'd1);
      checkOutput($sformatf("hold.full[%0d].head", k), 1'b1, PC0, 50'h3240, 2'd2);
      @(posedge clk);
    end
    @(negedge clk);
    bus.pfl1tomon_cand_retry = 1'b0;
    check("drain.retry_at_release", 64'(bus.l1topfl1_obs_retry), 64'd1);
    @(posedge clk); #1;
    checkOutput("drain.1", 1'b1, PC0, 50'h3280, 2'd3);
    check("drain.retry_released", 64'(bus.l1topfl1_obs_retry), 64'd0);
    @(posedge clk); #1;
    checkOutput("drain.2", 1'b1, PC0, 50'h32C0, 2'd3);
    @(negedge clk);
    bus.l1topfl1_obs_valid = 1'b0;
    @(posedge clk); #1;
    check("drain.empty", 64'(bus.pfl1tomon_cand_valid), 64'd0);

    // Reset pulse while the FIFO is full
    bus.pfl1tomon_cand_retry = 1'b1;
    applyStimulus(PC0, 50'h32C0);
    @(posedge clk);
    applyStimulus(PC0, 50'h3300);
    @(posedge clk);
    @(negedge clk);
    bus.l1topfl1_obs_valid = 1'b0;
    check("rstfull.obs_retry", 64'(bus.l1topfl1_obs_retry), 64'd1);
    check("rstfull.cand_valid", 64'(bus.pfl1tomon_cand_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rstmid.cand_valid", 64'(bus.pfl1tomon_cand_valid), 64'd0);
    check("rstmid.obs_retry",  64'(bus.l1topfl1_obs_retry),   64'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.pfl1tomon_cand_retry = 1'b0;
    vecs.push_back(mk(PC0, 50'h1200, 1'b0, 50'h0,    2'd0));
    vecs.push_back(mk(PC0, 50'h1240, 1'b0, 50'h0,    2'd0));
    vecs.push_back(mk(PC0, 50'h1280, 1'b0, 50'h0,    2'd0));
    vecs.push_back(mk(PC0, 50'h12C0, 1'b1, 50'h1300, 2'd2));
    runVectors("retrain");

    // Stride 8 inside one 64B line: repeats are dropped only with dedup
    vecs.push_back(mk(50'h420, 50'h1000, 1'b0,   50'h0,    2'd0));
    vecs.push_back(mk(50'h420, 50'h1008, 1'b0,   50'h0,    2'd0));
    vecs.push_back(mk(50'h420, 50'h1010, 1'b0,   50'h0,    2'd0));
    vecs.push_back(mk(50'h420, 50'h1018, 1'b1,   50'h1020, 2'd2));
    vecs.push_back(mk(50'h420, 50'h1020, !DEDUP, 50'h1028, 2'd3));
    vecs.push_back(mk(50'h420, 50'h1028, !DEDUP, 50'h1030, 2'd3));
    vecs.push_back(mk(50'h420, 50'h1030, !DEDUP, 50'h1038, 2'd3));
    vecs.push_back(mk(50'h420, 50'h1038, 1'b1,   50'h1040, 2'd3));
    runVectors("dedup");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
